pipe_stage_reg: RTL and testbench

//  Parametrised inter-stage pipeline register; successor to the fixed MEM/WB latch.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/pipe_skid_slot.sv | 56 +++++
 rtl/pipe_stage_reg.sv | 205 ++++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the inter-stage pipeline register family.
// Contents:
//   *_W_DEF          default widths, used as parameter defaults by pipe_stage_reg
//   stage_state_t    occupancy state of a stage (EMPTY, ONE, TWO); FULL aliases ONE
//   stage_payload_t  payload bundle {ctrl, rd, result, rdata} at the default widths
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned CTRL_W_DEF = 2;
  localparam int unsigned RD_W_DEF   = 5;
  localparam int unsigned CNT_W_DEF  = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  // The single-entry build only ever holds one beat, so "full" is the ONE state.
  localparam stage_state_t FULL = ONE;

  typedef struct packed {
    logic [CTRL_W_DEF-1:0] ctrl;
    logic [RD_W_DEF-1:0]   rd;
    logic [DATA_W_DEF-1:0] result;
    logic [DATA_W_DEF-1:0] rdata;
  } stage_payload_t;

endpackage

// File: rtl/pipe_skid_slot.sv
// One-entry skid slot: a payload register plus its valid flag.
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-low reset
//   clr          drop the held beat (valid cleared, payload held)
//   load         capture pay_in and mark valid
//   unload       the held beat has been taken; clear valid
//   pay_in       incoming payload
//   pay_out      held payload
//   valid_out    slot holds a beat
module pipe_skid_slot #(
  parameter int unsigned PAY_W = 135
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             unload,
  input  logic [PAY_W-1:0] pay_in,
  output logic [PAY_W-1:0] pay_out,
  output logic             valid_out
);

  logic [PAY_W-1:0] pay_q, pay_d;
  logic             valid_q, valid_d;

  // Next-state for the slot: clear beats load, load beats unload.
  always_comb begin
    pay_d   = pay_q;
    valid_d = valid_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pay_d   = pay_in;
    end else if (unload) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pay_q   <= {PAY_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      pay_q   <= pay_d;
      valid_q <= valid_d;
    end
  end

  assign pay_out   = pay_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake, flush
// and a saturating bubble counter. Bubbles present zero control so a killed
// slot never writes the register file.
// Build option: define PIPE_STAGE_SKID_EN to add a one-entry skid slot; in_ready
// then comes straight from a flop with no combinational path from out_ready.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   flush                 kill held and incoming beats at the next edge
//   in_valid / in_ready   upstream handshake
//   in_ctrl/rd/result/rdata   incoming payload
//   out_valid / out_ready downstream handshake
//   out_ctrl/rd/result/rdata  held payload (out_ctrl masked to 0 when !out_valid)
//   bubble_cnt            cycles with out_valid=0 && out_ready=1, saturating
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned RD_W   = RD_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_rdata,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int unsigned      PAY_W   = CTRL_W + RD_W + 2 * DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  stage_state_t     state_q, state_d;
  logic             valid_q, valid_d;
  logic [PAY_W-1:0] pay_q, pay_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic [PAY_W-1:0] in_pay;
  logic [CTRL_W-1:0] held_ctrl;
  logic             in_hs;
  logic             out_hs;

  assign in_pay = {in_ctrl, in_rd, in_result, in_rdata};
  assign in_hs  = in_valid & in_ready;
  assign out_hs = valid_q & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic             in_ready_q, in_ready_d;
  logic             skid_load;
  logic             skid_unload;
  logic [PAY_W-1:0] skid_pay;
  logic             skid_valid;

  pipe_skid_slot #(.PAY_W(PAY_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .clr       (flush),
    .load      (skid_load),
    .unload    (skid_unload),
    .pay_in    (in_pay),
    .pay_out   (skid_pay),
    .valid_out (skid_valid)
  );

  // Occupancy FSM with skid: a beat arriving while the output stalls parks in the slot.
  always_comb begin
    state_d     = state_q;
    pay_d       = pay_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_hs) begin
            state_d = ONE;
            pay_d   = in_pay;
          end else begin
            state_d = EMPTY;
          end
        end
        ONE: begin
          if (in_hs && out_hs) begin
            state_d = ONE;
            pay_d   = in_pay;
          end else if (in_hs) begin
            state_d   = TWO;
            skid_load = 1'b1;
          end else if (out_hs) begin
            state_d = EMPTY;
          end else begin
            state_d = ONE;
          end
        end
        TWO: begin
          // An empty slot in TWO can only come from a corrupted state; fall back to ONE.
          if (!skid_valid) begin
            state_d = ONE;
          end else if (out_hs) begin
            state_d     = ONE;
            pay_d       = skid_pay;
            skid_unload = 1'b1;
          end else begin
            state_d = TWO;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  // in_ready is registered so upstream never sees a path from out_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
`else
  // Occupancy FSM, single entry: FULL reloads on a concurrent in/out handshake.
  always_comb begin
    state_d = state_q;
    pay_d   = pay_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_hs) begin
            state_d = FULL;
            pay_d   = in_pay;
          end else begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_hs while FULL implies out_ready, so the held beat leaves as the new one lands.
          if (in_hs) begin
            state_d = FULL;
            pay_d   = in_pay;
          end else if (out_hs) begin
            state_d = EMPTY;
          end else begin
            state_d = FULL;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Accept when empty, or when the held beat is leaving this cycle.
  assign in_ready = ~valid_q | out_ready;
`endif

  // Bubble counter: counts downstream-ready cycles with nothing to give, saturating.
  always_comb begin
    if (!valid_q && out_ready && (bubble_q != CNT_MAX)) begin
      bubble_d = bubble_q + CNT_W'(1'b1);
    end else begin
      bubble_d = bubble_q;
    end
  end

  assign valid_d = (state_d != EMPTY);

  // Stage registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= EMPTY;
      valid_q  <= 1'b0;
      pay_q    <= {PAY_W{1'b0}};
      bubble_q <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      pay_q    <= pay_d;
      bubble_q <= bubble_d;
    end
  end

  assign {held_ctrl, out_rd, out_result, out_rdata} = pay_q;
  assign out_ctrl   = valid_q ? held_ctrl : {CTRL_W{1'b0}};
  assign out_valid  = valid_q;
  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int DW = 64;
  localparam int CW = 2;
  localparam int RW = 5;
  localparam int N6 = 300;
`ifdef PIPE_STAGE_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [RW-1:0] in_rd;
  logic [DW-1:0] in_result, in_rdata;

  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [RW-1:0] out_rd;
  logic [DW-1:0] out_result, out_rdata;
  logic [31:0]   bubble_cnt;

  logic          s_in_ready, s_out_valid;
  logic [CW-1:0] s_out_ctrl;
  logic [RW-1:0] s_out_rd;
  logic [DW-1:0] s_out_result, s_out_rdata;
  logic [2:0]    s_bubble_cnt;

  int total = 0;
  int bad   = 0;

  pipe_stage_reg u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_rd(in_rd), .in_result(in_result), .in_rdata(in_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_rd(out_rd), .out_result(out_result), .out_rdata(out_rdata),
    .bubble_cnt(bubble_cnt)
  );

  // Same stimulus, 3-bit counter, to exercise saturation.
  pipe_stage_reg #(.CNT_W(3)) u_dut_sat (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_rd(in_rd), .in_result(in_result), .in_rdata(in_rdata),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_ctrl(s_out_ctrl), .out_rd(s_out_rd), .out_result(s_out_result), .out_rdata(s_out_rdata),
    .bubble_cnt(s_bubble_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [63:0] q[$];
    logic        ihs, ohs;
    logic [63:0] seen;
    int          sent, recv, cycles;

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = 2'b00; in_rd = 5'd0; in_result = 64'd0; in_rdata = 64'd0;
    #3;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_bubble",    64'(bubble_cnt), 64'd0);
    check_eq("rst_in_ready",  64'(in_ready), 64'd1);
    tick();
    reset = 1'b1;

    // Idle with out_ready=1: main counter counts, 3-bit counter saturates at 7.
    out_ready = 1'b1;
    tick();
    check_eq("bub_first",     64'(bubble_cnt), 64'd1);
    check_eq("bub_sat_first", 64'(s_bubble_cnt), 64'd1);
    repeat (6) tick();
    check_eq("bub_7",         64'(bubble_cnt), 64'd7);
    check_eq("bub_sat_7",     64'(s_bubble_cnt), 64'd7);
    repeat (3) tick();
    check_eq("bub_10",        64'(bubble_cnt), 64'd10);
    check_eq("bub_sat_hold",  64'(s_bubble_cnt), 64'd7);

    // Streaming k=1..8; out_ready low on the first beat so no bubble is counted.
    for (int k = 1; k <= 8; k++) begin
      in_valid  = 1'b1;
      in_ctrl   = 2'b01;
      in_rd     = 5'(k);
      in_result = 64'(k);
      in_rdata  = 64'(k * 16);
      out_ready = (k != 1);
      #1;
      check_eq("t2_in_ready", 64'(in_ready), 64'd1);
      tick();
      check_eq("t2_result", out_result, 64'(k));
      check_eq("t2_valid",  64'(out_valid), 64'd1);
      if (k == 3 || k == 8) begin
        check_eq("t2_rdata", out_rdata, 64'(k * 16));
        check_eq("t2_ctrl",  64'(out_ctrl), 64'd1);
        check_eq("t2_rd",    64'(out_rd), 64'(k));
      end
    end
    check_eq("t2_bubble", 64'(bubble_cnt), 64'd10);

    // Stall while holding 0x5.
    in_result = 64'h5;
    tick();
    check_eq("t3_load5", out_result, 64'h5);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_result = (i == 0 || !SKID) ? 64'h6 : 64'h7;
      #1;
      check_eq("t3_in_ready", 64'(in_ready), (i == 0) ? 64'(SKID) : 64'd0);
      tick();
      check_eq("t3_hold", out_result, 64'h5);
      check_eq("t3_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    in_result = SKID ? 64'h7 : 64'h6;
    tick();
    check_eq("t3_next6", out_result, 64'h6);
    in_result = 64'h7;
    tick();
    check_eq("t3_next7", out_result, 64'h7);
    check_eq("t3_bubble", 64'(bubble_cnt), 64'd10);

    // Flush with a held beat and an incoming beat.
    flush = 1'b1; in_valid = 1'b1; in_ctrl = 2'b11; in_result = 64'hAA; out_ready = 1'b0;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check_eq("t4_valid",  64'(out_valid), 64'd0);
    check_eq("t4_ctrl",   64'(out_ctrl), 64'd0);
    check_eq("t4_held",   out_result, 64'h7);
    tick();
    tick();
    check_eq("t4_no_beat", 64'(out_valid), 64'd0);
    check_eq("t4_bubble",  64'(bubble_cnt), 64'd12);

    // Reset mid-stream while a beat is held.
    in_valid = 1'b1; in_ctrl = 2'b11; in_result = 64'h33; in_rdata = 64'h44; in_rd = 5'd9;
    tick();
    check_eq("t1_pre_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check_eq("t1_valid",  64'(out_valid), 64'd0);
    check_eq("t1_ctrl",   64'(out_ctrl), 64'd0);
    check_eq("t1_rd",     64'(out_rd), 64'd0);
    check_eq("t1_result", out_result, 64'd0);
    check_eq("t1_rdata",  out_rdata, 64'd0);
    check_eq("t1_bubble", 64'(bubble_cnt), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    check_eq("t1_bub_restart", 64'(bubble_cnt), 64'd1);
    check_eq("t1_dropped",     64'(out_valid), 64'd0);

    // Random handshakes with a scoreboard: strict FIFO, no drops or duplicates.
    sent = 0; recv = 0; cycles = 0; in_ctrl = 2'b10;
    while (recv < N6 && cycles < 20 * N6) begin
      in_valid  = (sent < N6) && ($urandom_range(0, 3) != 0);
      in_result = 64'h1000 + 64'(sent);
      in_rdata  = ~in_result;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      ihs  = in_valid && in_ready;
      ohs  = out_valid && out_ready;
      seen = out_result;
      @(posedge clk);
      if (ohs) begin
        if (q.size() == 0) begin
          check_eq("t6_extra_beat", 64'(q.size()), 64'd1);
        end else begin
          check_eq("t6_order", seen, q.pop_front());
        end
        recv++;
      end
      if (ihs) begin
        q.push_back(in_result);
        sent++;
      end
      #1;
      cycles++;
    end
    check_eq("t6_recv", 64'(recv), 64'(N6));
    check_eq("t6_left", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
